// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants and level function for the PWM peripheral
package pwm_pkg;

  localparam int PWM_CNT_W = 8;
  localparam logic [PWM_CNT_W-1:0] PWM_TOP = 8'd254;
  localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'd255;
  localparam int CLK_DIV_DEFAULT = 13;

  // Full-scale duty forces a solid high because the counter never reaches 255.
  function automatic logic pwm_level(input logic [PWM_CNT_W-1:0] cnt,
                                     input logic [PWM_CNT_W-1:0] duty);
    return (duty == DUTY_FULL) || (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_peripheral_if.sv
// rtl/pwm_peripheral_if.sv - register inputs and pin outputs of the PWM peripheral
interface pwm_peripheral_if;
  import pwm_pkg::*;

  logic [7:0]           en_reg_out_7_0;
  logic [7:0]           en_reg_out_15_8;
  logic [7:0]           en_reg_pwm_7_0;
  logic [7:0]           en_reg_pwm_15_8;
  logic [PWM_CNT_W-1:0] pwm_duty_cycle;
  logic [15:0]          out;

  modport master (
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
    output pwm_duty_cycle,
    input  out
  );

  modport slave (
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
    input  pwm_duty_cycle,
    output out
  );

endinterface

// File: rtl/pwm_timebase.sv
// rtl/pwm_timebase.sv - clock prescaler and 255-step PWM counter
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [PWM_CNT_W-1:0] cnt,
  output logic                 period_end
);

  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

  logic [PRE_W-1:0]     pre_q, pre_d;
  logic [PWM_CNT_W-1:0] cnt_q, cnt_d;
  logic                 tick;

  always_comb begin
    tick  = (pre_q == PRE_LAST);
    pre_d = tick ? '0 : pre_q + PRE_W'(1);
    cnt_d = cnt_q;
    if (tick) begin
      cnt_d = (cnt_q == PWM_TOP) ? '0 : cnt_q + PWM_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
    end
  end

  assign cnt        = cnt_q;
  assign period_end = tick && (cnt_q == PWM_TOP);

endmodule

// File: rtl/pwm_peripheral.sv
// rtl/pwm_peripheral.sv - duty shadow, per-channel output mux and pin register
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  pwm_peripheral_if.slave   bus
);

  logic [PWM_CNT_W-1:0] cnt;
  logic                 period_end;
  logic [PWM_CNT_W-1:0] duty_sh_q, duty_sh_d;
  logic [15:0]          out_q, out_d;
  logic [15:0]          en_out, en_pwm;
  logic                 lvl;

  pwm_timebase #(.CLK_DIV(CLK_DIV)) u_timebase (
    .clk        (clk),
    .rst        (rst),
    .cnt        (cnt),
    .period_end (period_end)
  );

  // Duty is only sampled at the period boundary so pulses are never truncated.
  always_comb begin
    en_out    = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
    en_pwm    = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
    duty_sh_d = period_end ? bus.pwm_duty_cycle : duty_sh_q;
    lvl       = pwm_level(cnt, duty_sh_q);
    out_d     = en_out & (~en_pwm | {16{lvl}});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_sh_q <= '0;
      out_q     <= '0;
    end else begin
      duty_sh_q <= duty_sh_d;
      out_q     <= out_d;
    end
  end

  assign bus.out = out_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// tb/tb_pwm_peripheral.sv - scoreboard bench for pwm_peripheral at the default divider
module tb_pwm_peripheral;

  localparam int PERIOD = 255 * 13;

  typedef struct {
    string       name;
    logic [31:0] value;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pwm_peripheral_if bus ();

  pwm_peripheral #(.CLK_DIV(13)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  exp_t        sb[$];
  logic [31:0] obs[$];

  int m_high[4];
  int m_split, m_pe, m_bad_pe, m_pre_high, m_timeout;

  task automatic set_regs(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
    bus.en_reg_out_7_0  = eo[7:0];
    bus.en_reg_out_15_8 = eo[15:8];
    bus.en_reg_pwm_7_0  = ep[7:0];
    bus.en_reg_pwm_15_8 = ep[15:8];
    bus.pwm_duty_cycle  = d;
  endtask

  task automatic push_exp(input string name, input logic [31:0] value);
    exp_t e;
    e.name  = name;
    e.value = value;
    sb.push_back(e);
  endtask

  // Waits for a period boundary, then samples n whole periods of out (out lags cnt by one clock).
  task automatic run_periods(input int n, input int chg_cnt, input logic [7:0] chg_duty);
    int  j;
    bit  done;
    for (int k = 0; k < 4; k++) m_high[k] = 0;
    m_split = 0; m_pe = 0; m_bad_pe = 0; m_pre_high = 0; m_timeout = 0;
    j = 0;
    @(negedge clk);
    while (!dut.period_end && j < 4000) begin
      if (bus.out !== 16'h0000) m_pre_high++;
      @(negedge clk);
      j++;
    end
    if (j >= 4000) begin
      m_timeout = 1;
      return;
    end
    @(negedge clk);
    done = 1'b0;
    for (j = 1; j <= n * PERIOD; j++) begin
      @(negedge clk);
      if (bus.out[0] === 1'b1) m_high[(j - 1) / PERIOD]++;
      if (bus.out !== 16'h0000 && bus.out !== 16'hFFFF) m_split++;
      if (dut.period_end) begin
        m_pe++;
        if (j % PERIOD != PERIOD - 1) m_bad_pe++;
      end
      if (!done && chg_cnt >= 0 && dut.cnt == chg_cnt[7:0]) begin
        bus.pwm_duty_cycle = chg_duty;
        done = 1'b1;
      end
    end
  endtask

  task automatic test_reset;
    exp_t e;
    logic [31:0] o;
    set_regs(16'h0000, 16'h0000, 8'h00);
    @(negedge clk);
    push_exp("reset_out", 32'h0);       obs.push_back(32'(bus.out));
    push_exp("reset_cnt", 32'h0);       obs.push_back(32'(dut.cnt));
    push_exp("reset_duty_sh", 32'h0);   obs.push_back(32'(dut.duty_sh_q));
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); checks++;
      if (o !== e.value) begin
        errors++;
        $display("FAIL %s: got %0d expected %0d", e.name, o, e.value);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_duty_80;
    exp_t e;
    logic [31:0] o;
    set_regs(16'hFFFF, 16'hFFFF, 8'h80);
    push_exp("d80_timeout", 0);
    push_exp("d80_first_period_low", 0);
    push_exp("d80_high0", 1664);
    push_exp("d80_high1", 1664);
    push_exp("d80_low0", 1651);
    push_exp("d80_low1", 1651);
    push_exp("d80_bits_identical", 0);
    push_exp("d80_period_ends", 2);
    push_exp("d80_period_len", 0);
    run_periods(2, -1, 8'h00);
    obs.push_back(m_timeout);
    obs.push_back(m_pre_high);
    obs.push_back(m_high[0]);
    obs.push_back(m_high[1]);
    obs.push_back(PERIOD - m_high[0]);
    obs.push_back(PERIOD - m_high[1]);
    obs.push_back(m_split);
    obs.push_back(m_pe);
    obs.push_back(m_bad_pe);
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); checks++;
      if (o !== e.value) begin
        errors++;
        $display("FAIL %s: got %0d expected %0d", e.name, o, e.value);
      end
    end
  endtask

  task automatic test_static;
    exp_t e;
    logic [31:0] o;
    int bad;
    set_regs(16'h0001, 16'h0000, 8'h80);
    @(negedge clk);
    push_exp("static_out", 32'h0001); obs.push_back(32'(bus.out));
    bad = 0;
    for (int i = 0; i < 2 * PERIOD + 100; i++) begin
      @(negedge clk);
      if (bus.out !== 16'h0001) bad++;
    end
    push_exp("static_hold_errs", 0); obs.push_back(bad);
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); checks++;
      if (o !== e.value) begin
        errors++;
        $display("FAIL %s: got %0d expected %0d", e.name, o, e.value);
      end
    end
  endtask

  task automatic test_extremes;
    exp_t e;
    logic [31:0] o;
    set_regs(16'hFFFF, 16'hFFFF, 8'h00);
    push_exp("d00_timeout", 0);
    push_exp("d00_high0", 0);
    push_exp("d00_high1", 0);
    push_exp("d00_bits_identical", 0);
    run_periods(2, -1, 8'h00);
    obs.push_back(m_timeout); obs.push_back(m_high[0]);
    obs.push_back(m_high[1]); obs.push_back(m_split);
    set_regs(16'hFFFF, 16'hFFFF, 8'hFF);
    push_exp("dff_timeout", 0);
    push_exp("dff_high0", PERIOD);
    push_exp("dff_high1", PERIOD);
    push_exp("dff_bits_identical", 0);
    run_periods(2, -1, 8'h00);
    obs.push_back(m_timeout); obs.push_back(m_high[0]);
    obs.push_back(m_high[1]); obs.push_back(m_split);
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); checks++;
      if (o !== e.value) begin
        errors++;
        $display("FAIL %s: got %0d expected %0d", e.name, o, e.value);
      end
    end
  endtask

  task automatic test_disabled;
    exp_t e;
    logic [31:0] o;
    int bad;
    set_regs(16'h0000, 16'hFFFF, 8'hFF);
    @(negedge clk);
    push_exp("dis_out", 32'h0000); obs.push_back(32'(bus.out));
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out !== 16'h0000) bad++;
    end
    push_exp("dis_hold_errs", 0); obs.push_back(bad);
    set_regs(16'h8000, 16'hFFFF, 8'hFF);
    @(negedge clk);
    push_exp("dis_en15_out", 32'h8000); obs.push_back(32'(bus.out));
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); checks++;
      if (o !== e.value) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h", e.name, o, e.value);
      end
    end
  endtask

  task automatic test_mid_change;
    exp_t e;
    logic [31:0] o;
    set_regs(16'hFFFF, 16'hFFFF, 8'h40);
    push_exp("mid_timeout", 0);
    push_exp("mid_high_cur", 832);
    push_exp("mid_high_next", 2496);
    push_exp("mid_period_ends", 2);
    run_periods(2, 100, 8'hC0);
    obs.push_back(m_timeout); obs.push_back(m_high[0]);
    obs.push_back(m_high[1]); obs.push_back(m_pe);
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); checks++;
      if (o !== e.value) begin
        errors++;
        $display("FAIL %s: got %0d expected %0d", e.name, o, e.value);
      end
    end
  endtask

  task automatic test_async_reset;
    exp_t e;
    logic [31:0] o;
    int n;
    int bad;
    set_regs(16'hFFFF, 16'hFFFF, 8'h80);
    n = 0;
    @(negedge clk);
    while (bus.out !== 16'hFFFF && n < 4000) begin
      @(negedge clk);
      n++;
    end
    push_exp("ar_reach_high", 1); obs.push_back(n < 4000);
    #1 rst = 1'b1;
    #1;
    push_exp("ar_out_immediate", 32'h0000); obs.push_back(32'(bus.out));
    push_exp("ar_cnt_immediate", 32'h0);    obs.push_back(32'(dut.cnt));
    #1 rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out !== 16'h0000) bad++;
    end
    push_exp("ar_cnt_hold0", 32'h0);   obs.push_back(32'(dut.cnt));
    push_exp("ar_out_low", 0);         obs.push_back(bad);
    @(negedge clk);
    push_exp("ar_cnt_step1", 32'h1);   obs.push_back(32'(dut.cnt));
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); checks++;
      if (o !== e.value) begin
        errors++;
        $display("FAIL %s: got %0d expected %0d", e.name, o, e.value);
      end
    end
  endtask

  initial begin
    test_reset();
    test_duty_80();
    test_static();
    test_extremes();
    test_disabled();
    test_mid_change();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
